// File: rtl/hamming_enc_engine.sv
// SECDED Hamming encoder engine: reads NUM_MSGS 11-bit messages from byte-wide
// data memory and writes the 16-bit {data, p8, p4, p2, p1, p0} codewords back.
module hamming_enc_engine #(
    parameter int NUM_MSGS = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    localparam int IDX_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic [11:1]        r_msg;

    logic [ADDR_W-1:0]  w_offset;
    logic [ADDR_W-1:0]  w_src_lo;
    logic [ADDR_W-1:0]  w_dst_lo;
    logic               w_p8, w_p4, w_p2, w_p1, w_p0;
    logic [15:0]        w_cw;
    logic               w_unused_hi;

    // Message i occupies bytes BASE+2i and BASE+2i+1; sums wrap at ADDR_W bits.
    assign w_offset = ADDR_W'({r_idx, 1'b0});
    assign w_src_lo = ADDR_W'(SRC_BASE) + w_offset;
    assign w_dst_lo = ADDR_W'(DST_BASE) + w_offset;

    assign w_p8 = ^r_msg[11:5];
    assign w_p4 = (^r_msg[11:8]) ^ (^r_msg[4:2]);
    assign w_p2 = r_msg[11] ^ r_msg[10] ^ r_msg[7] ^ r_msg[6] ^ r_msg[4] ^ r_msg[3] ^ r_msg[1];
    assign w_p1 = r_msg[11] ^ r_msg[9] ^ r_msg[7] ^ r_msg[5] ^ r_msg[4] ^ r_msg[2] ^ r_msg[1];
    assign w_p0 = (^r_msg) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;
    assign w_cw = {r_msg[11:5], w_p8, r_msg[4:2], w_p4, r_msg[1], w_p2, w_p1, w_p0};

    // Upper bits of the message high byte carry no data.
    assign w_unused_hi = ^mem_rd_data[7:3];

    assign done = (r_state == DONE);
    assign busy = (r_state != IDLE) && (r_state != DONE);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_msg   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            if (r_state == RD_LO) r_msg[8:1]  <= mem_rd_data;
            if (r_state == RD_HI) r_msg[11:9] <= mem_rd_data[2:0];
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        w_next_state = r_state;
        w_next_idx   = r_idx;
        mem_addr     = '0;
        mem_wr_en    = 1'b0;
        mem_wr_data  = '0;
        case (r_state)
            IDLE, DONE: begin
                if (req) begin
                    w_next_idx   = '0;
                    w_next_state = RD_LO;
                end
            end
            RD_LO: begin
                mem_addr     = w_src_lo;
                w_next_state = RD_HI;
            end
            RD_HI: begin
                mem_addr     = w_src_lo + ADDR_W'(1);
                w_next_state = WR_LO;
            end
            WR_LO: begin
                mem_addr     = w_dst_lo;
                mem_wr_en    = 1'b1;
                mem_wr_data  = w_cw[7:0];
                w_next_state = WR_HI;
            end
            WR_HI: begin
                mem_addr    = w_dst_lo + ADDR_W'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = w_cw[15:8];
                if (r_idx == LAST_IDX) begin
                    w_next_state = DONE;
                end else begin
                    w_next_idx   = r_idx + IDX_W'(1);
                    w_next_state = RD_LO;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed bench for hamming_enc_engine with a behavioural asynchronous-read
// byte memory; covers latency, restart, reset abort and codeword contents.
module tb_hamming_enc_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       done;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];
    logic [7:0] src_copy [0:29];
    int         wr_cnt = 0;
    int         oob_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    hamming_enc_engine dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
            wr_cnt = wr_cnt + 1;
            if (mem_addr < 8'd30 || mem_addr > 8'd59) oob_cnt = oob_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder straight from the parity equations.
    function automatic logic [15:0] ref_cw(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    // Bit index j of the codeword is Hamming position j; returns {syndrome, overall parity}.
    function automatic logic [4:0] hchk(input logic [15:0] cw);
        logic [3:0] s;
        s = '0;
        for (int j = 1; j < 16; j++) if (cw[j]) s = s ^ 4'(j);
        return {s, ^cw};
    endfunction

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic start_and_wait(input bit hold_req, output int lat);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_req) req = 1'b0;
        wait_done(lat);
    endtask

    task automatic clear_dst();
        for (int a = 30; a < 60; a++) mem[a] = 8'hA5;
        wr_cnt  = 0;
        oob_cnt = 0;
    endtask

    logic [15:0] exp_cw [0:5];
    int          lat;

    initial begin
        exp_cw[0] = 16'h0000;
        exp_cw[1] = 16'hFFFF;
        exp_cw[2] = 16'h000F;
        exp_cw[3] = 16'h8117;
        exp_cw[4] = 16'h0000;
        exp_cw[5] = 16'h8117;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_wren", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wr_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);

        // Directed messages 0..5; slot 4 has garbage in bits [7:3] only,
        // slot 5 keeps d11 set under the garbage (0xFC -> d[11:9]=3'b100).
        @(negedge clk);
        mem[0]  = 8'h00; mem[1]  = 8'h00;
        mem[2]  = 8'hFF; mem[3]  = 8'h07;
        mem[4]  = 8'h01; mem[5]  = 8'h00;
        mem[6]  = 8'h00; mem[7]  = 8'h04;
        mem[8]  = 8'h00; mem[9]  = 8'hF8;
        mem[10] = 8'h00; mem[11] = 8'hFC;
        clear_dst();

        // req held high: ignored while busy, then restarts straight out of DONE.
        start_and_wait(1'b1, lat);
        check("lat_first", lat, 60);
        check("done_busy", busy, 0);
        check("done_wren", mem_wr_en, 0);
        @(posedge clk);
        #1;
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        req = 1'b0;
        wait_done(lat);
        check("lat_restart", lat, 60);
        for (int i = 0; i < 15; i++) begin
            logic [15:0] e;
            e = (i < 6) ? exp_cw[i] : 16'h0000;
            check($sformatf("dir_lo%0d", i), mem[30 + 2 * i], e[7:0]);
            check($sformatf("dir_hi%0d", i), mem[31 + 2 * i], e[15:8]);
        end
        check("dir_wr_cnt", wr_cnt, 60);
        check("dir_oob", oob_cnt, 0);

        // Random messages checked against the reference and by syndrome.
        @(negedge clk);
        for (int a = 0; a < 30; a++) begin
            mem[a]      = 8'($urandom);
            src_copy[a] = mem[a];
        end
        clear_dst();
        start_and_wait(1'b0, lat);
        check("lat_rand", lat, 60);
        for (int i = 0; i < 15; i++) begin
            logic [15:0] cw;
            logic [11:1] d;
            int          nz;
            d  = {mem[2 * i + 1][2:0], mem[2 * i]};
            cw = {mem[31 + 2 * i], mem[30 + 2 * i]};
            check($sformatf("rand_cw%0d", i), cw, ref_cw(d));
            check($sformatf("rand_syn%0d", i), hchk(cw), 0);
            nz = 0;
            for (int b = 0; b < 16; b++) if (hchk(cw ^ (16'h1 << b)) != 5'd0) nz++;
            check($sformatf("rand_flip%0d", i), nz, 16);
        end
        begin
            int diffs;
            diffs = 0;
            for (int a = 0; a < 30; a++) if (mem[a] !== src_copy[a]) diffs++;
            check("src_intact", diffs, 0);
        end
        check("rand_oob", oob_cnt, 0);
        check("rand_wr_cnt", wr_cnt, 30);

        // Reset sampled on the edge that commits message 1's low byte.
        @(negedge clk);
        mem[0] = 8'h01; mem[1] = 8'h00;
        mem[2] = 8'h00; mem[3] = 8'h04;
        clear_dst();
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_addr", mem_addr, 32);
        check("pre_rst_wren", mem_wr_en, 1);
        check("pre_rst_wdata", mem_wr_data, 8'h17);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_wren", mem_wr_en, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_wren", mem_wr_en, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        check("abort_wr_cnt", wr_cnt, 3);
        check("abort_m0_lo", mem[30], 8'h0F);
        check("abort_m0_hi", mem[31], 8'h00);
        check("abort_m1_lo", mem[32], 8'h17);
        check("abort_m1_hi", mem[33], 8'hA5);
        check("abort_m2_lo", mem[34], 8'hA5);

        start_and_wait(1'b0, lat);
        check("lat_after_rst", lat, 60);
        check("rerun_m1_lo", mem[32], 8'h17);
        check("rerun_m1_hi", mem[33], 8'h81);
        check("rerun_wr_cnt", wr_cnt, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
